// File: rtl/trace_pkg.sv
// Shared definitions for the AXI trace trigger: FSM state encoding,
// capture direction modes, debug register indices and CTRL bit positions.
package trace_pkg;

    // Trigger FSM states; encoding is visible to software through STATUS[1:0]
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } trace_state_e;

    // Direction qualification applied to address events
    typedef enum logic [1:0] {
        MODE_ANY   = 2'd0,
        MODE_WRITE = 2'd1,
        MODE_READ  = 2'd2,
        MODE_OFF   = 2'd3
    } trace_mode_e;

    // Debug register indices
    localparam logic [2:0] REG_ID     = 3'd0;
    localparam logic [2:0] REG_CTRL   = 3'd1;
    localparam logic [2:0] REG_MATCH  = 3'd2;
    localparam logic [2:0] REG_MASK   = 3'd3;
    localparam logic [2:0] REG_POST   = 3'd4;
    localparam logic [2:0] REG_STATUS = 3'd5;
    localparam logic [2:0] REG_REMAIN = 3'd6;
    localparam logic [2:0] REG_NTH    = 3'd7;

    // CTRL register bit positions
    localparam int CTRL_ARM_BIT   = 0;
    localparam int CTRL_ABORT_BIT = 1;
    localparam int CTRL_MODE_LSB  = 2;
    localparam int CTRL_MODE_MSB  = 3;

    // Width of the saturating match counter reported in STATUS[31:16]
    localparam int MATCH_CNT_W = 16;

endpackage

// File: rtl/axi_trace_trigger_if.sv
// Debug register port and AXI address-event port of the trace trigger.
// The master side is the debugger / event source, the slave side is the trigger.
interface axi_trace_trigger_if;

    logic        dbg_rd;
    logic        dbg_wr;
    logic [2:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic [31:0] dbg_rdata;

    logic        ev_valid;
    logic        ev_write;
    logic [31:0] ev_addr;

    modport master (
        output dbg_rd,
        output dbg_wr,
        output dbg_addr,
        output dbg_wdata,
        input  dbg_rdata,
        output ev_valid,
        output ev_write,
        output ev_addr
    );

    modport slave (
        input  dbg_rd,
        input  dbg_wr,
        input  dbg_addr,
        input  dbg_wdata,
        output dbg_rdata,
        input  ev_valid,
        input  ev_write,
        input  ev_addr
    );

endinterface

// File: rtl/trace_addr_match.sv
// Combinational address matcher: masked compare of the event address against
// the MATCH register plus the direction filter selected by MODE.
module trace_addr_match
    import trace_pkg::*;
(
    input  logic        ev_valid,
    input  logic        ev_write,
    input  logic [31:0] ev_addr,
    input  logic [31:0] match_val,
    input  logic [31:0] mask_val,
    input  trace_mode_e mode,
    output logic        hit
);

    logic addr_eq;
    logic dir_ok;

    // Masked address equality and direction qualification of one event
    always_comb begin
        addr_eq = ((ev_addr & mask_val) == (match_val & mask_val));
        dir_ok  = 1'b0;
        case (mode)
            MODE_ANY:   dir_ok = 1'b1;
            MODE_WRITE: dir_ok = ev_write;
            MODE_READ:  dir_ok = ~ev_write;
            default:    dir_ok = 1'b0;
        endcase
        hit = ev_valid && addr_eq && dir_ok;
    end

endmodule

// File: rtl/axi_trace_trigger.sv
// AXI address trace trigger: watches completed AW/AR handshakes, arms a trace
// buffer, fires a trigger on a masked address match and keeps capture enabled
// for a programmable number of post-trigger events.
// Optional feature macro: AXI_TRACE_TRIG_NTH_EN -- register 7 becomes NTH and
// the trigger fires on the NTH match instead of the first.
module axi_trace_trigger
    import trace_pkg::*;
#(
    parameter int          POST_W = 9,
    parameter logic [31:0] ID     = 32'h54524731
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    axi_trace_trigger_if.slave   bus,
    output logic                 cap_en,
    output logic                 cap_clr,
    output logic                 trig
);

    trace_state_e             state_q;
    trace_mode_e              mode_q;
    logic [31:0]              match_q;
    logic [31:0]              mask_q;
    logic [POST_W-1:0]        post_q;
    logic [POST_W-1:0]        remain_q;
    logic [MATCH_CNT_W-1:0]   cnt_q;
    logic [31:0]              rdata_q;
    logic                     trig_q;
`ifdef AXI_TRACE_TRIG_NTH_EN
    logic [15:0]              nth_q;
`endif

    logic                     ctrl_wr;
    logic                     arm_req;
    logic                     abort_req;
    logic                     ev_live;
    logic                     hit;
    logic                     nth_reached;
    logic [31:0]              rd_mux;

    function automatic logic [MATCH_CNT_W-1:0] sat_inc(input logic [MATCH_CNT_W-1:0] v);
        return (v == {MATCH_CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // Decode CTRL writes; a CTRL write suppresses any coincident event
    always_comb begin
        ctrl_wr   = bus.dbg_wr && (bus.dbg_addr == REG_CTRL);
        arm_req   = ctrl_wr && bus.dbg_wdata[CTRL_ARM_BIT];
        abort_req = ctrl_wr && bus.dbg_wdata[CTRL_ABORT_BIT];
        ev_live   = bus.ev_valid && !ctrl_wr;
    end

    trace_addr_match u_match (
        .ev_valid  (ev_live),
        .ev_write  (bus.ev_write),
        .ev_addr   (bus.ev_addr),
        .match_val (match_q),
        .mask_val  (mask_q),
        .mode      (mode_q),
        .hit       (hit)
    );

    // Decide whether the current match is the one that should fire the trigger
    always_comb begin
`ifdef AXI_TRACE_TRIG_NTH_EN
        nth_reached = (({1'b0, cnt_q} + 17'd1) >= {1'b0, nth_q});
`else
        nth_reached = 1'b1;
`endif
    end

    // Capture window and buffer clear; ABORT in the same write cancels the clear
    always_comb begin
        cap_en  = (state_q == ST_ARMED) || (state_q == ST_POST);
        cap_clr = arm_req && !abort_req;
        trig    = trig_q;
    end

    // Trigger FSM with post-trigger countdown, match counter and trigger pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            remain_q <= '0;
            cnt_q    <= '0;
            trig_q   <= 1'b0;
        end else begin
            trig_q <= 1'b0;
            if (abort_req) begin
                state_q <= ST_IDLE;
            end else if (arm_req) begin
                state_q <= ST_ARMED;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    ST_ARMED: begin
                        if (hit) begin
                            cnt_q <= sat_inc(cnt_q);
                            if (nth_reached) begin
                                trig_q <= 1'b1;
                                if (post_q == '0) begin
                                    state_q  <= ST_DONE;
                                    remain_q <= '0;
                                end else begin
                                    state_q  <= ST_POST;
                                    remain_q <= post_q - 1'b1;
                                end
                            end
                        end
                    end
                    ST_POST: begin
                        if (ev_live) begin
                            if (remain_q == '0) begin
                                state_q <= ST_DONE;
                            end else begin
                                remain_q <= remain_q - 1'b1;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Configuration registers; match setup is frozen once a capture is armed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= MODE_ANY;
            match_q <= '0;
            mask_q  <= '0;
            post_q  <= '0;
`ifdef AXI_TRACE_TRIG_NTH_EN
            nth_q   <= '0;
`endif
        end else if (bus.dbg_wr) begin
            case (bus.dbg_addr)
                REG_CTRL: mode_q <= trace_mode_e'(bus.dbg_wdata[CTRL_MODE_MSB:CTRL_MODE_LSB]);
                REG_MATCH: begin
                    if (state_q == ST_IDLE) match_q <= bus.dbg_wdata;
                end
                REG_MASK: begin
                    if (state_q == ST_IDLE) mask_q <= bus.dbg_wdata;
                end
                REG_POST: begin
                    if (state_q == ST_IDLE) post_q <= bus.dbg_wdata[POST_W-1:0];
                end
`ifdef AXI_TRACE_TRIG_NTH_EN
                REG_NTH: nth_q <= bus.dbg_wdata[15:0];
`endif
                default: begin
                end
            endcase
        end
    end

    // Register read multiplexer
    always_comb begin
        rd_mux = '0;
        case (bus.dbg_addr)
            REG_ID:     rd_mux = ID;
            REG_CTRL:   rd_mux = {28'd0, mode_q, 2'b00};
            REG_MATCH:  rd_mux = match_q;
            REG_MASK:   rd_mux = mask_q;
            REG_POST:   rd_mux = 32'(post_q);
            REG_STATUS: rd_mux = {cnt_q, 14'd0, state_q};
            REG_REMAIN: rd_mux = 32'(remain_q);
`ifdef AXI_TRACE_TRIG_NTH_EN
            REG_NTH:    rd_mux = {16'd0, nth_q};
`endif
            default:    rd_mux = '0;
        endcase
    end

    // Registered read data, updated only on a read strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (bus.dbg_rd) begin
            rdata_q <= rd_mux;
        end
    end

    assign bus.dbg_rdata = rdata_q;

endmodule
